// File: rtl/dmem_interface.sv
// Data-memory access unit: turns a load/store request into one valid/ready bus transaction and returns aligned, extended load data.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (adds the misaligned output and completes misaligned accesses without a bus cycle).
module dmem_interface (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [3:0]  strb,
   input  logic [31:0] wb_mask,
   input  logic [4:0]  wb_msb_bit,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        read_valid,
   output logic        write_ready,
   output logic [31:0] rdata,
   output logic        access_fault,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_rsp_valid,
   output logic        bus_rsp_ready,
   input  logic [31:0] bus_rsp_rdata,
   input  logic        bus_rsp_err
`ifdef DMEM_MISALIGN_CHECK_EN
   ,
   output logic        misaligned
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mask_q, mask_d;
   logic [4:0]  msb_q, msb_d;
   logic [31:0] baddr_q, baddr_d;
   logic [31:0] bwdata_q, bwdata_d;
   logic [3:0]  bwstrb_q, bwstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
`ifdef DMEM_MISALIGN_CHECK_EN
   logic        mis_q, mis_d;
`endif

   // Shift the lane down, mask it, then fill everything above the sign bit when it is set.
   function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                              input logic [31:0] mask, input logic [4:0] msb);
      logic [31:0] t;
      logic [31:0] ext;
      t   = (word >> {off, 3'b000}) & mask;
      ext = (32'hFFFF_FFFF << msb) << 1'b1;
      if ((msb != 5'd0) && t[msb]) begin
         load_align = t | ext;
      end else begin
         load_align = t;
      end
   endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
   function automatic logic is_misaligned(input logic [3:0] s, input logic [1:0] off);
      is_misaligned = ((s == 4'b0011) && off[0]) || ((s == 4'b1111) && (off != 2'b00));
   endfunction
`endif

   // Next-state and payload capture for the request/response sequence.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      off_d    = off_q;
      mask_d   = mask_q;
      msb_d    = msb_q;
      baddr_d  = baddr_q;
      bwdata_d = bwdata_q;
      bwstrb_d = bwstrb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_d    = mis_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (write_enable || read_enable) begin
               we_d     = write_enable;
               off_d    = addr[1:0];
               mask_d   = wb_mask;
               msb_d    = wb_msb_bit;
               baddr_d  = {addr[31:2], 2'b00};
               bwdata_d = wdata << {addr[1:0], 3'b000};
               bwstrb_d = strb << addr[1:0];
               err_d    = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
               if (is_misaligned(strb, addr[1:0])) begin
                  mis_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  mis_d   = 1'b0;
                  state_d = S_REQ;
               end
`else
               state_d = S_REQ;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus_req_ready) begin
               state_d = S_RESP;
            end else begin
               state_d = S_REQ;
            end
         end
         S_RESP: begin
            if (bus_rsp_valid) begin
               err_d = bus_rsp_err;
               if (!we_q) begin
                  rdata_d = load_align(bus_rsp_rdata, off_q, mask_q, msb_q);
               end else begin
                  rdata_d = rdata_q;
               end
               state_d = S_DONE;
            end else begin
               state_d = S_RESP;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and payload registers; reset clears every output source at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         off_q    <= 2'b00;
         mask_q   <= 32'h0000_0000;
         msb_q    <= 5'd0;
         baddr_q  <= 32'h0000_0000;
         bwdata_q <= 32'h0000_0000;
         bwstrb_q <= 4'b0000;
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         mis_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         off_q    <= off_d;
         mask_q   <= mask_d;
         msb_q    <= msb_d;
         baddr_q  <= baddr_d;
         bwdata_q <= bwdata_d;
         bwstrb_q <= bwstrb_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
`ifdef DMEM_MISALIGN_CHECK_EN
         mis_q    <= mis_d;
`endif
      end
   end

   assign bus_req_valid = (state_q == S_REQ);
   assign bus_rsp_ready = (state_q == S_RESP);
   assign bus_we        = we_q;
   assign bus_addr      = baddr_q;
   assign bus_wdata     = bwdata_q;
   assign bus_wstrb     = bwstrb_q;
   assign read_valid    = (state_q == S_DONE) && !we_q;
   assign write_ready   = (state_q == S_DONE) && we_q;
   assign access_fault  = (state_q == S_DONE) && err_q;
   assign rdata         = rdata_q;
`ifdef DMEM_MISALIGN_CHECK_EN
   assign misaligned    = (state_q == S_DONE) && mis_q;
`endif

endmodule
